spi_slave_mode: RTL and testbench

//  Full-duplex SPI slave, successor to the fixed-width mode-0 receive-only slave.
//  - Adds CPOL/CPHA mode selection, parametrised word width and MISO transmit.
//  - Accepts back-to-back words within one ss_n frame.
//  - Sits between the external SPI pins and the register/AXI4-Lite side; all internal logic runs on clk.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_mode.sv | 171 +++++++++++++++++
 tb/tb_spi_slave_mode.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave.
// Latency: none (types and a pure combinational function).
// Backpressure: not applicable.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // The leading edge is the one that leaves the idle level of sclk.
    function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
// Latency: STAGES clk from pin to edge strobe; each strobe lasts one clk.
// Backpressure: none, edges are strobed unconditionally.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    // Synchroniser chain plus one clk of history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_mode.sv
// Full-duplex SPI slave with selectable CPOL/CPHA and DATA_W-bit words, MSB first.
// Latency: rx_valid one clk after the last synchronised sample edge of a word.
// Backpressure: none on rx (rx_data overwritten); tx via one-word holding buffer (tx_ready).
module spi_slave_mode
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int              CW       = $clog2(DATA_W);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
    localparam logic            CPOL_L   = (CPOL != 0);
    localparam logic            CPHA_L   = (CPHA != 0);

    logic                   sclk_rise, sclk_fall;
    logic                   lead_e, trail_e, sample_e, drive_e;
    logic [SYNC_STAGES-1:0] ss_sync_q, mosi_sync_q;
    logic                   ss_s, mosi_s;
    state_t                 state_q, state_d;
    logic                   enter, leave, active, load;
    logic [CW-1:0]          cnt_q;
    logic [DATA_W-1:0]      rx_sh, tx_sh, buf_q;
    logic                   buf_full;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CPOL_L)
    ) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // Level-only synchronisers; ss_n idles deselected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign lead_e   = lead_edge(CPOL_L, sclk_rise, sclk_fall);
    assign trail_e  = lead_edge(!CPOL_L, sclk_rise, sclk_fall);
    assign sample_e = CPHA_L ? trail_e : lead_e;
    assign drive_e  = CPHA_L ? lead_e : trail_e;

    // Frame state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Frame entry/exit follow the synchronised slave select.
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        leave   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ss_s) begin
                    state_d = ACTIVE;
                    enter   = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end
            end
        endcase
    end

    assign active = (state_q == ACTIVE);
    // A word boundary on the drive side: CPHA=0 presents bit 0 before the first edge.
    assign load   = (!CPHA_L && enter) || (active && !leave && drive_e && cnt_q == '0);

    // Receive path: shift on sample edges, publish each full word, flag aborted words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            rx_sh     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (enter) begin
                cnt_q <= '0;
                rx_sh <= '0;
            end else if (leave) begin
                cnt_q     <= '0;
                frame_err <= (cnt_q != '0);
            end else if (active && sample_e) begin
                rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};
                if (cnt_q == LAST_BIT) begin
                    cnt_q    <= '0;
                    rx_data  <= {rx_sh[DATA_W-2:0], mosi_s};
                    rx_valid <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Transmit path: holding buffer feeds the shifter at word boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sh       <= '0;
            buf_q       <= '0;
            buf_full    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load) begin
                if (buf_full) begin
                    tx_sh    <= buf_q;
                    buf_full <= 1'b0;
                end else if (tx_valid) begin
                    // Word arriving in the load cycle bypasses the buffer.
                    tx_sh <= tx_data;
                end else begin
                    tx_sh       <= '0;
                    tx_underrun <= 1'b1;
                end
            end else begin
                if (active && !leave && drive_e) begin
                    tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                end
                if (tx_valid && !buf_full) begin
                    buf_q    <= tx_data;
                    buf_full <= 1'b1;
                end
            end
        end
    end

    assign tx_ready = ~buf_full;
    assign busy     = active;
    assign miso_oe  = active;
    assign miso     = active & tx_sh[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: three instances (mode 0/8b, mode 3/8b, mode 1/16b) behind a shared master.
// Latency: master half-period is H clk, well above the slave's synchroniser delay.
// Backpressure: tx words are offered only while the selected instance shows tx_ready.
module tb_spi_slave_mode;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          sel = 0;
    logic        sclk_d = 1'b0, ss_d = 1'b1, mosi_d = 1'b0, tx_v = 1'b0;
    logic [15:0] tx_dat = 16'h0;
    int          errors = 0, checks = 0;

    logic        m0_miso, m0_oe, m0_rdy, m0_rxv, m0_ur, m0_fe, m0_busy;
    logic [7:0]  m0_rx;
    logic        m3_miso, m3_oe, m3_rdy, m3_rxv, m3_ur, m3_fe, m3_busy;
    logic [7:0]  m3_rx;
    logic        m1_miso, m1_oe, m1_rdy, m1_rxv, m1_ur, m1_fe, m1_busy;
    logic [15:0] m1_rx;

    logic        miso_m, oe_m, rdy_m, rxv_m, ur_m, fe_m, busy_m;
    logic [15:0] rx_m;

    logic [15:0] rx_got[$];
    int          ur_cnt = 0, fe_cnt = 0;

    always #5 clk = ~clk;

    spi_slave_mode #(.DATA_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .reset_n(reset_n),
        .sclk(sel == 0 ? sclk_d : 1'b0), .ss_n(sel == 0 ? ss_d : 1'b1), .mosi(mosi_d),
        .miso(m0_miso), .miso_oe(m0_oe),
        .tx_data(tx_dat[7:0]), .tx_valid(tx_v && sel == 0), .tx_ready(m0_rdy),
        .rx_data(m0_rx), .rx_valid(m0_rxv), .tx_underrun(m0_ur), .frame_err(m0_fe), .busy(m0_busy)
    );

    spi_slave_mode #(.DATA_W(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_m3 (
        .clk(clk), .reset_n(reset_n),
        .sclk(sel == 1 ? sclk_d : 1'b1), .ss_n(sel == 1 ? ss_d : 1'b1), .mosi(mosi_d),
        .miso(m3_miso), .miso_oe(m3_oe),
        .tx_data(tx_dat[7:0]), .tx_valid(tx_v && sel == 1), .tx_ready(m3_rdy),
        .rx_data(m3_rx), .rx_valid(m3_rxv), .tx_underrun(m3_ur), .frame_err(m3_fe), .busy(m3_busy)
    );

    spi_slave_mode #(.DATA_W(16), .CPOL(0), .CPHA(1), .SYNC_STAGES(2)) u_m1 (
        .clk(clk), .reset_n(reset_n),
        .sclk(sel == 2 ? sclk_d : 1'b0), .ss_n(sel == 2 ? ss_d : 1'b1), .mosi(mosi_d),
        .miso(m1_miso), .miso_oe(m1_oe),
        .tx_data(tx_dat), .tx_valid(tx_v && sel == 2), .tx_ready(m1_rdy),
        .rx_data(m1_rx), .rx_valid(m1_rxv), .tx_underrun(m1_ur), .frame_err(m1_fe), .busy(m1_busy)
    );

    // View of whichever instance the master is currently talking to.
    always_comb begin
        miso_m = m0_miso; oe_m = m0_oe; rdy_m = m0_rdy; rxv_m = m0_rxv;
        ur_m = m0_ur; fe_m = m0_fe; busy_m = m0_busy; rx_m = {8'h00, m0_rx};
        if (sel == 1) begin
            miso_m = m3_miso; oe_m = m3_oe; rdy_m = m3_rdy; rxv_m = m3_rxv;
            ur_m = m3_ur; fe_m = m3_fe; busy_m = m3_busy; rx_m = {8'h00, m3_rx};
        end else if (sel == 2) begin
            miso_m = m1_miso; oe_m = m1_oe; rdy_m = m1_rdy; rxv_m = m1_rxv;
            ur_m = m1_ur; fe_m = m1_fe; busy_m = m1_busy; rx_m = m1_rx;
        end
    end

    // Record received words and count pulses of the selected instance.
    always @(negedge clk) begin
        if (rxv_m) rx_got.push_back(rx_m);
        if (ur_m) ur_cnt++;
        if (fe_m) fe_cnt++;
    end

    function automatic logic cpol_of(input int s);
        return (s == 1);
    endfunction

    function automatic logic cpha_of(input int s);
        return (s != 0);
    endfunction

    function automatic int width_of(input int s);
        return (s == 2) ? 16 : 8;
    endfunction

    task automatic select(input int s);
        ss_d   = 1'b1;
        sclk_d = cpol_of(s);
        sel    = s;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_begin();
        sclk_d = cpol_of(sel);
        ss_d   = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (H) @(negedge clk);
        ss_d = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    // Master side of the protocol, MSB first; returns the bits read from miso.
    task automatic xfer(input int nbits, input logic [15:0] mo, output logic [15:0] mi);
        logic cpol, cpha;
        cpol = cpol_of(sel);
        cpha = cpha_of(sel);
        mi   = 16'h0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi_d = mo[i];
                repeat (H) @(negedge clk);
                mi     = {mi[14:0], miso_m};
                sclk_d = ~cpol;
                repeat (H) @(negedge clk);
                sclk_d = cpol;
            end else begin
                sclk_d = ~cpol;
                mosi_d = mo[i];
                repeat (H) @(negedge clk);
                mi     = {mi[14:0], miso_m};
                sclk_d = cpol;
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic push_tx(input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_m && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy_m !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_wait: tx_ready=%b after %0d clk, required 1", rdy_m, n);
        end
        tx_dat = d;
        tx_v   = 1'b1;
        @(negedge clk);
        tx_v   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({miso_m, oe_m, rdy_m, busy_m, rxv_m, ur_m, fe_m} !== 7'b0010000) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d: miso,oe,rdy,busy,rxv,ur,fe=%b required 0010000", s,
                         {miso_m, oe_m, rdy_m, busy_m, rxv_m, ur_m, fe_m});
            end
            checks++;
            if (rx_m !== 16'h0) begin
                errors++;
                $display("FAIL reset_rx_data inst=%0d: got %h required 0000", s, rx_m);
            end
        end
        sel = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (H) @(negedge clk);
        checks++;
        if (busy_m !== 1'b0 || rdy_m !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b tx_ready=%b required 0/1", busy_m, rdy_m);
        end
    endtask

    task automatic test_mode0_basic();
        logic [15:0] mi;
        int base;
        select(0);
        push_tx(16'h003C);
        base = rx_got.size();
        frame_begin();
        checks++;
        if (busy_m !== 1'b1 || oe_m !== 1'b1) begin
            errors++;
            $display("FAIL m0_frame_start: busy=%b miso_oe=%b required 1/1", busy_m, oe_m);
        end
        xfer(8, 16'h00A5, mi);
        frame_end();
        checks++;
        if (rx_got.size() != base + 1) begin
            errors++;
            $display("FAIL m0_rx_count: got %0d required 1", rx_got.size() - base);
        end
        checks++;
        if (rx_got[base] !== 16'h00A5) begin
            errors++;
            $display("FAIL m0_rx_data: got %h required 00a5", rx_got[base]);
        end
        checks++;
        if (mi !== 16'h003C) begin
            errors++;
            $display("FAIL m0_miso_word: got %h required 003c", mi);
        end
        checks++;
        if (busy_m !== 1'b0 || oe_m !== 1'b0 || miso_m !== 1'b0) begin
            errors++;
            $display("FAIL m0_frame_end: busy=%b miso_oe=%b miso=%b required 0/0/0", busy_m, oe_m, miso_m);
        end
    endtask

    task automatic test_mode3();
        logic [15:0] mi;
        int base, ur0;
        select(1);
        push_tx(16'h005A);
        base = rx_got.size();
        ur0  = ur_cnt;
        frame_begin();
        xfer(8, 16'h0081, mi);
        frame_end();
        checks++;
        if (rx_got.size() != base + 1 || rx_got[base] !== 16'h0081) begin
            errors++;
            $display("FAIL m3_rx: count %0d word %h required 1 word 0081", rx_got.size() - base, rx_got[base]);
        end
        checks++;
        if (mi !== 16'h005A) begin
            errors++;
            $display("FAIL m3_miso_word: got %h required 005a", mi);
        end
        checks++;
        if (ur_cnt != ur0) begin
            errors++;
            $display("FAIL m3_underrun: got %0d pulses required 0", ur_cnt - ur0);
        end
    endtask

    task automatic test_burst();
        logic [15:0] mo [3];
        logic [15:0] tw [3];
        logic [15:0] mi [3];
        int base;
        mo[0] = 16'h0011; mo[1] = 16'h0022; mo[2] = 16'h0033;
        tw[0] = 16'h00AA; tw[1] = 16'h00BB; tw[2] = 16'h00CC;
        select(0);
        push_tx(tw[0]);
        base = rx_got.size();
        fork
            begin
                frame_begin();
                for (int k = 0; k < 3; k++) xfer(8, mo[k], mi[k]);
                frame_end();
            end
            begin
                push_tx(tw[1]);
                push_tx(tw[2]);
            end
        join
        checks++;
        if (rx_got.size() != base + 3) begin
            errors++;
            $display("FAIL burst_rx_count: got %0d required 3", rx_got.size() - base);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx_got[base + k] !== mo[k] || mi[k] !== tw[k]) begin
                errors++;
                $display("FAIL burst_word%0d: rx %h miso %h required rx %h miso %h",
                         k, rx_got[base + k], mi[k], mo[k], tw[k]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [15:0] mi0, mi1;
        int base, ur0;
        select(0);
        push_tx(16'h0077);
        base = rx_got.size();
        ur0  = ur_cnt;
        frame_begin();
        xfer(8, 16'h0012, mi0);
        xfer(8, 16'h0034, mi1);
        checks++;
        if (ur_cnt - ur0 != 1) begin
            errors++;
            $display("FAIL underrun_count: got %0d pulses during word 2, required 1", ur_cnt - ur0);
        end
        frame_end();
        checks++;
        if (mi0 !== 16'h0077 || mi1 !== 16'h0000) begin
            errors++;
            $display("FAIL underrun_miso: got %h,%h required 0077,0000", mi0, mi1);
        end
        checks++;
        if (rx_got.size() != base + 2 || rx_got[base] !== 16'h0012 || rx_got[base + 1] !== 16'h0034) begin
            errors++;
            $display("FAIL underrun_rx: count %0d words %h,%h required 2 words 0012,0034",
                     rx_got.size() - base, rx_got[base], rx_got[base + 1]);
        end
    endtask

    task automatic test_frame_err();
        logic [15:0] mi, tw;
        int base, fe0;
        select(0);
        base = rx_got.size();
        fe0  = fe_cnt;
        frame_begin();
        xfer(5, 16'h00C8, mi);
        frame_end();
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL frame_err_pulse: got %0d pulses required 1", fe_cnt - fe0);
        end
        checks++;
        if (rx_got.size() != base) begin
            errors++;
            $display("FAIL frame_err_no_rx: got %0d rx_valid required 0", rx_got.size() - base);
        end
        tw = 16'($urandom_range(0, 255));
        push_tx(tw);
        frame_begin();
        xfer(8, 16'h00F0, mi);
        frame_end();
        checks++;
        if (rx_got.size() != base + 1 || rx_got[base] !== 16'h00F0) begin
            errors++;
            $display("FAIL after_err_rx: count %0d word %h required 1 word 00f0", rx_got.size() - base, rx_got[base]);
        end
        checks++;
        if (mi !== tw || fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL after_err_tx: miso %h frame_err total %0d required %h and 1", mi, fe_cnt - fe0, tw);
        end
    endtask

    task automatic test_mode1_16();
        logic [15:0] mi, mo, tw;
        int base;
        select(2);
        for (int r = 0; r < 2; r++) begin
            mo = (r == 0) ? 16'hBEEF : 16'($urandom);
            tw = (r == 0) ? 16'hBEEF : 16'($urandom);
            push_tx(tw);
            base = rx_got.size();
            frame_begin();
            xfer(16, mo, mi);
            frame_end();
            checks++;
            if (rx_got.size() != base + 1 || rx_got[base] !== mo) begin
                errors++;
                $display("FAIL m1_rx round %0d: count %0d word %h required 1 word %h",
                         r, rx_got.size() - base, rx_got[base], mo);
            end
            checks++;
            if (mi !== tw) begin
                errors++;
                $display("FAIL m1_miso round %0d: got %h required %h", r, mi, tw);
            end
        end
    endtask

    // Random three-word frames on every mode: rx must equal what was sent, miso what was fed.
    task automatic test_random();
        logic [15:0] mo [3];
        logic [15:0] tw [3];
        logic [15:0] mi [3];
        logic [15:0] mask;
        int base, w;
        for (int s = 0; s < 3; s++) begin
            select(s);
            w    = width_of(s);
            mask = (w == 16) ? 16'hFFFF : 16'h00FF;
            for (int k = 0; k < 3; k++) begin
                mo[k] = 16'($urandom) & mask;
                tw[k] = 16'($urandom) & mask;
            end
            push_tx(tw[0]);
            base = rx_got.size();
            fork
                begin
                    frame_begin();
                    for (int k = 0; k < 3; k++) xfer(w, mo[k], mi[k]);
                    frame_end();
                end
                begin
                    push_tx(tw[1]);
                    push_tx(tw[2]);
                end
            join
            checks++;
            if (rx_got.size() != base + 3) begin
                errors++;
                $display("FAIL rand_rx_count inst=%0d: got %0d required 3", s, rx_got.size() - base);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rx_got[base + k] !== mo[k] || mi[k] !== tw[k]) begin
                    errors++;
                    $display("FAIL rand_word inst=%0d k=%0d: rx %h miso %h required rx %h miso %h",
                             s, k, rx_got[base + k], mi[k], mo[k], tw[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] mi, mo, tw;
        int base, fe0;
        select(0);
        push_tx(16'h0099);
        frame_begin();
        xfer(3, 16'h00E0, mi);
        base = rx_got.size();
        fe0  = fe_cnt;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({miso_m, oe_m, rdy_m, busy_m, rxv_m, ur_m, fe_m} !== 7'b0010000) begin
            errors++;
            $display("FAIL mid_reset_outputs: miso,oe,rdy,busy,rxv,ur,fe=%b required 0010000",
                     {miso_m, oe_m, rdy_m, busy_m, rxv_m, ur_m, fe_m});
        end
        checks++;
        if (rx_m !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_rx_data: got %h required 0000", rx_m);
        end
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++;
        if (fe_cnt != fe0 || rx_got.size() != base) begin
            errors++;
            $display("FAIL mid_reset_silent: frame_err %0d rx_valid %0d required 0/0", fe_cnt - fe0, rx_got.size() - base);
        end
        mo = 16'($urandom_range(0, 255));
        tw = 16'($urandom_range(0, 255));
        push_tx(tw);
        frame_begin();
        xfer(8, mo, mi);
        frame_end();
        checks++;
        if (rx_got.size() != base + 1 || rx_got[base] !== mo || mi !== tw) begin
            errors++;
            $display("FAIL post_reset_frame: rx count %0d word %h miso %h required 1 word %h miso %h",
                     rx_got.size() - base, rx_got[base], mi, mo, tw);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_mode3();
        test_burst();
        test_underrun();
        test_frame_err();
        test_mode1_16();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
